// File: rtl/dif_radix2_pkg.sv
// Shared constants, sample word and FSM state for the FFT output sink.
// The m_mag field exists only when FFT_SINK_MAG_EN is defined.
package dif_radix2_pkg;
  localparam int DATA_W  = 17;
  localparam int FFT_NUM = 6;
  localparam int FFT_LEN = 1 << FFT_NUM;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } sink_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
    logic [FFT_NUM-1:0]       bin;
`ifdef FFT_SINK_MAG_EN
    logic [2*DATA_W-1:0]      mag;
`endif
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);
endpackage

// File: rtl/dif_radix2_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and synchronous active-low reset.
// Head data reads as zero while the FIFO is empty.
module dif_radix2_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 128
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = i_wr_en && (r_level != LW'(DEPTH));
  assign w_do_rd = i_rd_en && (r_level != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; the empty mask below hides stale contents.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_level   = r_level;
endmodule

// File: rtl/dif_radix2_64p_fft_sink.sv
// Frames the 64-point DIF FFT output stream, admits whole frames into a show-ahead FIFO.
// Optional m_mag output (re^2 + im^2) is enabled by defining FFT_SINK_MAG_EN.
//
// state  | meaning
// ACCEPT | current frame is written into the FIFO
// DROP   | current frame is discarded (no room at its bin-0 sample)
module dif_radix2_64p_fft_sink
  import dif_radix2_pkg::*;
#(
  parameter int FIFO_DEPTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic signed [DATA_W-1:0]      i_din_re,
  input  logic signed [DATA_W-1:0]      i_din_im,
  input  logic                          i_din_valid,
  output logic signed [DATA_W-1:0]      o_m_re,
  output logic signed [DATA_W-1:0]      o_m_im,
  output logic [FFT_NUM-1:0]            o_m_bin,
  output logic                          o_m_sof,
  output logic                          o_m_eof,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic [CNT_WIDTH-1:0]          o_drop_cnt,
`ifdef FFT_SINK_MAG_EN
  output logic [2*DATA_W-1:0]           o_m_mag,
`endif
  input  logic                          i_clr
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  sink_state_e          r_state;
  logic [FFT_NUM-1:0]   r_bin;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [LW-1:0]        w_level;
  logic                 w_sof_in;
  logic                 w_room;
  logic                 w_drop_now;
  logic                 w_wr_en;
  sample_t              w_wr_word;
  sample_t              w_rd_word;

  assign w_sof_in   = i_din_valid && (r_bin == '0);
  // Same-cycle read is deliberately not credited as free space.
  assign w_room     = (w_level <= LW'(FIFO_DEPTH - FFT_LEN));
  assign w_drop_now = w_sof_in && !w_room;
  assign w_wr_en    = i_din_valid && (w_sof_in ? w_room : (r_state == ACCEPT));
  assign w_cnt_base = i_clr ? '0 : r_drop_cnt;

`ifdef FFT_SINK_MAG_EN
  logic signed [2*DATA_W-1:0] w_sq_re;
  logic signed [2*DATA_W-1:0] w_sq_im;
  assign w_sq_re = i_din_re * i_din_re;
  assign w_sq_im = i_din_im * i_din_im;
`endif

  always_comb begin
    w_wr_word     = '0;
    w_wr_word.re  = i_din_re;
    w_wr_word.im  = i_din_im;
    w_wr_word.bin = r_bin;
`ifdef FFT_SINK_MAG_EN
    w_wr_word.mag = $unsigned(w_sq_re) + $unsigned(w_sq_im);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bin <= '0;
    end else if (i_din_valid) begin
      r_bin <= r_bin + 1'b1;
    end
  end

  // A drop decision in the same cycle as clr counts from the cleared value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ACCEPT;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_sof_in) r_state <= w_room ? ACCEPT : DROP;
      r_overflow <= w_drop_now | (r_overflow & ~i_clr);
      if (w_drop_now)
        r_drop_cnt <= (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + 1'b1;
      else
        r_drop_cnt <= w_cnt_base;
    end
  end

  dif_radix2_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_word),
    .i_rd_en   (i_m_ready),
    .o_rd_data (w_rd_word),
    .o_level   (w_level)
  );

  assign o_m_valid  = (w_level != '0);
  assign o_m_re     = w_rd_word.re;
  assign o_m_im     = w_rd_word.im;
  assign o_m_bin    = w_rd_word.bin;
  assign o_m_sof    = o_m_valid && (w_rd_word.bin == '0);
  assign o_m_eof    = o_m_valid && (w_rd_word.bin == FFT_NUM'(FFT_LEN - 1));
  assign o_level    = w_level;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
`ifdef FFT_SINK_MAG_EN
  assign o_m_mag    = w_rd_word.mag;
`endif
endmodule

// File: tb/tb_dif_radix2_64p_fft_sink.sv
// Directed self-checking bench for dif_radix2_64p_fft_sink (m_mag checks when FFT_SINK_MAG_EN is defined).
module tb_dif_radix2_64p_fft_sink;
  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [16:0] din_re, din_im;
  logic               din_valid;
  logic signed [16:0] m_re, m_im;
  logic [5:0]         m_bin;
  logic               m_sof, m_eof, m_valid, m_ready;
  logic [7:0]         level;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic               clr;
`ifdef FFT_SINK_MAG_EN
  logic [33:0]        m_mag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dif_radix2_64p_fft_sink dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_din_re    (din_re),
    .i_din_im    (din_im),
    .i_din_valid (din_valid),
    .o_m_re      (m_re),
    .o_m_im      (m_im),
    .o_m_bin     (m_bin),
    .o_m_sof     (m_sof),
    .o_m_eof     (m_eof),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_level     (level),
    .o_overflow  (overflow),
    .o_drop_cnt  (drop_cnt),
`ifdef FFT_SINK_MAG_EN
    .o_m_mag     (m_mag),
`endif
    .i_clr       (clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int re, input int im);
    din_valid = 1'b1;
    din_re    = 17'(re);
    din_im    = 17'(im);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input int first_bin);
    for (int b = first_bin; b < 64; b++) send(b, -b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    int bad;
    logic last_eof;

    rst_n = 1'b0; din_re = '0; din_im = '0; din_valid = 1'b0; m_ready = 1'b0; clr = 1'b0;
    idle(2);
    chk("reset_outputs", {m_valid, m_sof, m_eof, m_re, m_im, m_bin, level, overflow, drop_cnt}, 64'd0);
    rst_n = 1'b1;

    // 1: two back-to-back frames, streaming out with one cycle latency
    m_ready = 1'b1;
    bad = 0;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 64; b++) begin
        send(b, -b);
        if ({m_valid, m_bin, m_re, m_im, m_sof, m_eof} !==
            {1'b1, 6'(b), 17'(b), 17'(-b), (b == 0), (b == 63)}) bad++;
        if (b == 0 || b == 63)
          chk("stream_edge_sample", {m_valid, m_bin, m_re, m_im, m_sof, m_eof},
              {1'b1, 6'(b), 17'(b), 17'(-b), (b == 0), (b == 63)});
      end
    end
    chk("stream_all_samples", 64'(bad), 64'd0);
    tick();
    chk("stream_drained", {m_valid, level, overflow}, {1'b0, 8'd0, 1'b0});

    // 2: stalled sink, third frame dropped at its sof
    m_ready = 1'b0;
    send_frame(0);
    send_frame(0);
    chk("two_frames_level", 64'(level), 64'd128);
    chk("head_held", {m_valid, m_bin, m_sof, m_re}, {1'b1, 6'd0, 1'b1, 17'd0});
    send(0, 0);
    chk("drop_at_sof", {overflow, drop_cnt, level}, {1'b1, 16'd1, 8'd128});
    send_frame(1);
    chk("drop_level_held", {level, drop_cnt}, {8'd128, 16'd1});
    m_ready = 1'b1;
    n = 0; bad = 0; last_eof = 1'b0;
    while (m_valid && n < 200) begin
      if (m_bin !== 6'(n % 64) || m_re !== 17'(n % 64)) bad++;
      last_eof = m_eof;
      n++;
      tick();
    end
    chk("drain_count", 64'(n), 64'd128);
    chk("drain_order", 64'(bad), 64'd0);
    chk("drain_last_eof", 64'(last_eof), 64'd1);

    // 3: admission boundary, level 64 accepted, level 65 dropped
    m_ready = 1'b0;
    send_frame(0);
    chk("preload_64", 64'(level), 64'd64);
    send(0, 0);
    chk("accept_at_64", {level, drop_cnt}, {8'd65, 16'd1});
    send_frame(1);
    chk("accept_fills", 64'(level), 64'd128);
    m_ready = 1'b1;
    idle(63);
    m_ready = 1'b0;
    chk("preload_65", 64'(level), 64'd65);
    send(0, 0);
    chk("drop_at_65", {level, drop_cnt, overflow}, {8'd65, 16'd2, 1'b1});
    send_frame(1);

    // 4: same-cycle read not credited; clr racing a drop
    m_ready = 1'b1;
    send(0, 0);
    chk("drop_with_read", {level, drop_cnt}, {8'd64, 16'd3});
    send_frame(1);
    chk("drop_frame_no_write", {level, drop_cnt}, {8'd1, 16'd3});
    m_ready = 1'b0;
    send_frame(0);
    chk("accept_at_1", 64'(level), 64'd65);
    clr = 1'b1;
    send(0, 0);
    clr = 1'b0;
    chk("clr_and_drop", {overflow, drop_cnt}, {1'b1, 16'd1});
    send_frame(1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_alone", {overflow, drop_cnt, level}, {1'b0, 16'd0, 8'd65});

    // 5: reset mid-frame
    m_ready = 1'b1;
    for (int b = 0; b < 30; b++) send(b, -b);
    rst_n = 1'b0;
    din_valid = 1'b1; din_re = 17'd30; din_im = -17'sd30;
    tick();
    din_valid = 1'b0;
    chk("midframe_reset", {m_valid, m_sof, m_eof, m_re, m_im, m_bin, level, overflow, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    send(5, 7);
    chk("post_reset_bin0", {m_valid, m_bin, m_sof, m_re, m_im}, {1'b1, 6'd0, 1'b1, 17'd5, 17'd7});

`ifdef FFT_SINK_MAG_EN
    send(3, -4);
    chk("mag_3_4", {m_bin, m_mag}, {6'd1, 34'd25});
    send(-65536, -65536);
    chk("mag_min", {m_bin, m_mag}, {6'd2, 34'h2_0000_0000});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dif_radix2_64p_fft_sink.md
Name: dif_radix2_64p_fft_sink

Overview:
Output framing and buffering stage placed directly downstream of the 64-point radix-2 DIF FFT top. It consumes the FFT's unbackpressured dout_re/dout_im/dout_valid stream and tags each sample with its bin index and start/end-of-frame markers. Samples are buffered in a synchronous FIFO and presented on a valid/ready interface. Admission is frame-granular, so downstream logic never sees a partial frame.

Parameters:
DATA_WIDTH, 17, width of signed real/imag samples (matches FFT DATA_WIDTH_OUT)
FFT_NUM, 6, log2 of frame length; frame length FFT_LEN = 2^FFT_NUM = 64
FIFO_DEPTH, 128, FIFO entries; power of two, >= FFT_LEN
CNT_WIDTH, 16, width of dropped-frame counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
din_re  in  DATA_WIDTH  FFT real output, two's complement
din_im  in  DATA_WIDTH  FFT imag output, two's complement
din_valid  in  1  FFT output valid; no backpressure toward the FFT
m_re  out  DATA_WIDTH  buffered real sample
m_im  out  DATA_WIDTH  buffered imag sample
m_bin  out  FFT_NUM  bin index of m_re/m_im
m_sof  out  1  high when m_bin==0
m_eof  out  1  high when m_bin==FFT_LEN-1
m_valid  out  1  head-of-FIFO valid
m_ready  in  1  downstream accept
level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set when any frame is dropped
drop_cnt  out  CNT_WIDTH  dropped-frame count, saturating
clr  in  1  synchronous pulse; clears overflow and drop_cnt

Behaviour:
- Reset: bin counter=0, FIFO pointers=0, level=0, state=ACCEPT. Outputs m_valid, m_sof, m_eof, overflow=0; drop_cnt=0; m_re, m_im, m_bin=0.
- Bin counter: increments only on din_valid and wraps FFT_LEN-1 to 0. Gaps in din_valid do not advance it. It is bin-accurate because the FFT control is reset by the same rst_n.
- FSM states: ACCEPT, DROP. The decision is made only on a din_valid cycle with bin==0.
  - free = FIFO_DEPTH - level, sampled in that cycle. A same-cycle read is not counted toward free.
  - free >= FFT_LEN -> ACCEPT for the whole frame.
  - Otherwise -> DROP for the whole frame: overflow<=1, drop_cnt<=drop_cnt+1 (saturating at all-ones).
  - The state holds until the next bin==0 valid sample.
- ACCEPT: each din_valid writes {re, im, bin} into the FIFO. Overflow inside a frame cannot occur because space was reserved at sof.
- DROP: samples are discarded and the FIFO is not written.
- Output: show-ahead FIFO. m_* is driven from the head entry; m_valid = (level != 0).
  - Transfer occurs when m_valid && m_ready.
  - A sample written at cycle N is visible on m_* at cycle N+1 (1-cycle latency).
  - m_* is held stable while m_valid && !m_ready.
  - When the FIFO is empty, m_re/m_im/m_bin read as 0.
- Simultaneous read and write: level is unchanged. Read when empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- clr together with a new drop decision in the same cycle: the drop wins, giving overflow=1 and drop_cnt=1.
- Reset mid-frame: all state is cleared, and the next din_valid is treated as bin 0.

Optional Feature:
Macro FFT_SINK_MAG_EN.
- Defined: adds output m_mag [2*DATA_WIDTH-1:0] = re*re + im*im (unsigned), computed on the write path and stored in the FIFO word. m_mag aligns with m_re/m_im, adds no extra latency, and resets to 0.
- Undefined: no m_mag port, no multipliers, FIFO word width = 2*DATA_WIDTH+FFT_NUM.

Decomposition:
- Shared package dif_radix2_pkg holds:
  - FFT_NUM and FFT_LEN constants
  - the sample word typedef {re, im, bin[, mag]}
  - the FSM state enum {ACCEPT, DROP}
- Sub-module dif_radix2_sync_fifo: parameterised show-ahead synchronous FIFO with level output, synchronous active-low reset.
- The top contains the bin counter, FSM, counters and optional magnitude logic.

Test Plan:
1. Two back-to-back frames, din_re=bin, din_im=-bin, m_ready=1 -> 128 outputs one cycle after input; m_bin 0..63 twice; m_sof at bins 0, m_eof at bins 63; overflow=0.
2. m_ready=0, three frames -> frames 1-2 stored with level=128; frame 3 dropped, overflow=1, drop_cnt=1, level stays 128. Then m_ready=1 -> exactly 128 outputs, ending with m_eof.
3. Boundary: preload level=64 then sof -> frame accepted, level ends at 128. Preload level=65 then sof -> frame dropped, drop_cnt increments.
4. Level=65 with m_ready=1 in the sof cycle -> still dropped (same-cycle read not counted). Also: clr and a drop in the same cycle -> overflow=1, drop_cnt=1.
5. Assert rst_n=0 at input bin 30 for one cycle -> all outputs 0 next cycle; the following din_valid is emitted with m_bin=0 and m_sof=1.
6. FFT_SINK_MAG_EN defined:
   - re=3, im=-4 -> m_mag=25.
   - re=im=-65536 -> m_mag=8589934592 (2^33).
